// File: rtl/mest_pro_fetch.sv
// Instruction fetch front-end: streams ROM words into a 2-entry skid FIFO until a
// halt opcode or the last ROM address. Optional MEST_FETCH_INSTR_COUNT_EN adds o_instr_count.
module mest_pro_fetch #(
  parameter int OP_CODE_SIZE                = 4,
  parameter int INSTRUCTION_SIZE            = OP_CODE_SIZE + 8 + 8 + 8,
  parameter int ROM_DEPTH                   = 65536,
  parameter logic [OP_CODE_SIZE-1:0] HALT_OP = 4'hF,
  localparam int ADDR_W                     = $clog2(ROM_DEPTH)
) (
  input  logic                        clk,
  input  logic                        i_reset_n,
  input  logic                        i_start,
  output logic                        o_rom_en,
  output logic [ADDR_W-1:0]           o_rom_addr,
  input  logic [INSTRUCTION_SIZE-1:0] i_rom_data,
  output logic [INSTRUCTION_SIZE-1:0] o_instr,
  output logic                        o_instr_valid,
  input  logic                        i_instr_ready,
  output logic                        o_busy,
`ifdef MEST_FETCH_INSTR_COUNT_EN
  output logic [15:0]                 o_instr_count,
`endif
  output logic                        o_all_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                      state_q;
  logic [ADDR_W-1:0]           pc_q, rom_addr_q;
  logic                        rom_en_q, data_vld_q, rd_last_q, data_last_q, issued_last_q;
  logic [INSTRUCTION_SIZE-1:0] mem_q [2];
  logic                        wr_ptr_q, rd_ptr_q;
  logic [1:0]                  cnt_q;
  logic                        busy_q, all_done_q;

  logic                        fire, is_halt, push, pop, stop_run, issue, iss_last;
  logic [1:0]                  cnt_d;
  logic [ADDR_W-1:0]           iss_addr;

  always_comb begin
    // Returning data only counts while running; anything arriving later is a discarded read.
    fire     = data_vld_q && (state_q == RUN);
    is_halt  = fire && (i_rom_data[INSTRUCTION_SIZE-1 -: OP_CODE_SIZE] == HALT_OP);
    push     = fire && !is_halt;
    pop      = (cnt_q != 2'd0) && i_instr_ready;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    stop_run = is_halt || (fire && data_last_q);
    iss_addr = (state_q == IDLE) ? '0 : pc_q;
    iss_last = (iss_addr == ADDR_W'(ROM_DEPTH - 1));
    // Credit check: buffered words plus the read whose data lands next cycle must leave a slot.
    issue    = ((state_q == IDLE) && i_start) ||
               ((state_q == RUN) && !stop_run && !issued_last_q &&
                (({1'b0, cnt_d} + {2'b00, rom_en_q}) < 3'd2));
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      rom_addr_q    <= '0;
      rom_en_q      <= 1'b0;
      data_vld_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      data_last_q   <= 1'b0;
      issued_last_q <= 1'b0;
      mem_q[0]      <= '0;
      mem_q[1]      <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      all_done_q    <= 1'b0;
    end else begin
      rom_en_q    <= issue;
      data_vld_q  <= rom_en_q;
      rd_last_q   <= issue && iss_last;
      data_last_q <= rd_last_q;
      if (issue) begin
        rom_addr_q    <= iss_addr;
        pc_q          <= iss_last ? iss_addr : iss_addr + ADDR_W'(1);
        issued_last_q <= iss_last;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= i_rom_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q      <= cnt_d;
      all_done_q <= 1'b0;
      case (state_q)
        IDLE: if (i_start) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
        RUN: if (stop_run) state_q <= DRAIN;
        DRAIN: if (cnt_q == 2'd0) begin
          state_q    <= DONE;
          busy_q     <= 1'b0;
          all_done_q <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEST_FETCH_INSTR_COUNT_EN
  logic [15:0] icnt_q;
  always_ff @(posedge clk) begin
    if (!i_reset_n)                         icnt_q <= '0;
    else if ((state_q == IDLE) && i_start)  icnt_q <= '0;
    else if (pop && (icnt_q != 16'hFFFF))   icnt_q <= icnt_q + 16'd1;
  end
  assign o_instr_count = icnt_q;
`endif

  assign o_rom_en      = rom_en_q;
  assign o_rom_addr    = rom_addr_q;
  assign o_instr       = mem_q[rd_ptr_q];
  assign o_instr_valid = (cnt_q != 2'd0);
  assign o_busy        = busy_q;
  assign o_all_done    = all_done_q;

endmodule

// File: doc/mest_pro_fetch.md
MEST_PRO_FETCH -- requirements
Module: mest_pro_fetch

Interface
REQ-001 SHALL have parameter OP_CODE_SIZE, default 4, opcode width.
REQ-002 SHALL have parameter INSTRUCTION_SIZE, default OP_CODE_SIZE+8+8+8 (28), instruction word width.
REQ-003 SHALL have parameter ROM_DEPTH, default 65536, instruction ROM words; ADDR_W = $clog2(ROM_DEPTH) (16).
REQ-004 SHALL have parameter HALT_OP, default 4'hF, opcode that ends a program.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 i_reset_n  input  1  reset, synchronous, active-low.
REQ-007 i_start  input  1  one-cycle pulse, begins fetch at address 0.
REQ-008 o_rom_en  output  1  ROM read strobe.
REQ-009 o_rom_addr  output  ADDR_W  ROM read address.
REQ-010 i_rom_data  input  INSTRUCTION_SIZE  ROM read data, valid exactly 1 cycle after o_rom_en.
REQ-011 o_instr  output  INSTRUCTION_SIZE  instruction to execute stage; [27:24] opcode, [23:16] dest, [15:8] src A, [7:0] src B.
REQ-012 o_instr_valid  output  1  o_instr holds an instruction.
REQ-013 i_instr_ready  input  1  execute stage accepts o_instr this cycle.
REQ-014 o_busy  output  1  program in progress.
REQ-015 o_all_done  output  1  one-cycle pulse, program finished and all instructions dispatched.

Function
REQ-016 States: IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: i_start=1 -> PC=0, RUN; i_start ignored in every other state.
REQ-018 RUN: o_rom_en=1, o_rom_addr=PC, PC+1 whenever (buffer entries + reads in flight) < 2.
REQ-019 Returned word with opcode != HALT_OP SHALL be written to a 2-entry FIFO; FIFO head drives o_instr, o_instr_valid = FIFO non-empty.
REQ-020 Transfer occurs when o_instr_valid & i_instr_ready; head pops same cycle; o_instr stable while valid & !ready.
REQ-021 Simultaneous push and pop SHALL keep occupancy unchanged, order preserved.
REQ-022 Returned word with opcode == HALT_OP SHALL not be pushed; no further reads issued; state -> DRAIN.
REQ-023 Read issued at PC = ROM_DEPTH-1 SHALL be the last; PC not wrapped; after its data is pushed, state -> DRAIN.
REQ-024 DRAIN: no reads; when FIFO empty -> DONE.
REQ-025 DONE: o_all_done=1 for exactly one cycle, then IDLE.
REQ-026 o_busy=1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-027 Minimum latency: i_start at cycle N -> o_rom_en at N+1 -> o_instr_valid at N+3.
REQ-028 Halt as first word (address 0) SHALL produce no valid instruction and o_all_done 3 cycles after read issue.

Reset
REQ-029 i_reset_n=0 at a rising edge SHALL force: state IDLE, PC=0, FIFO empty, in-flight read discarded.
REQ-030 Reset values: o_rom_en=0, o_rom_addr=0, o_instr=0, o_instr_valid=0, o_busy=0, o_all_done=0.
REQ-031 Reset mid-program SHALL abort with no o_all_done pulse; ROM data returning the cycle after reset release SHALL be ignored.

Configuration
REQ-032 Macro MEST_FETCH_INSTR_COUNT_EN defined: adds output o_instr_count (16 bits), cleared on reset and on accepted i_start, +1 per completed transfer, saturates at 16'hFFFF, held after o_all_done.
REQ-033 Macro undefined: port o_instr_count and its counter absent; all other behaviour identical.

Verification
REQ-034 ROM {0:28'h1_01_02_03, 1:28'h2_04_05_06, 2:28'hF_00_00_00}, ready tied 1 -> o_instr 28'h1010203 then 28'h2040506 on consecutive cycles, o_all_done one cycle after FIFO empties, halt word never valid.
REQ-035 Same ROM, i_instr_ready=0 for 5 cycles after first valid -> o_instr holds 28'h1010203, at most 2 reads outstanding+buffered, order preserved after ready=1.
REQ-036 ROM word 0 = 28'hF_00_00_00 -> o_instr_valid never asserts, o_all_done pulses, o_busy falls.
REQ-037 ROM_DEPTH=8, no halt word -> exactly 8 instructions dispatched, o_rom_addr never exceeds 7, o_all_done pulses once.
REQ-038 i_reset_n=0 for 1 cycle after 2nd transfer -> all outputs at reset values next cycle, no o_all_done; new i_start restarts from address 0.
REQ-039 With MEST_FETCH_INSTR_COUNT_EN, REQ-034 stimulus -> o_instr_count = 2 at o_all_done; second i_start clears it to 0.
